// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing a byte-wide data memory between the CPU
// and the UART engine; each 32-bit word moves as four big-endian bytes.
module dmem_port_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [31:0]       wdata0,
    output logic              done0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata1,
    output logic              done1,
    output logic [31:0]       rdata,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        LAST,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-3:0] word_q, word_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        grant_q, grant_d;
    logic              last_q, last_d;
    logic              pick1;
    logic [7:0]        byte_sel;
    logic              unused_addr_bits;

    // Word-aligned accesses: the low address bits never reach the memory.
    assign unused_addr_bits = ^{addr0[1:0], addr1[1:0]};

    // On a conflict the port that did not win last time is served.
    assign pick1 = req1 & (~req0 | ~last_q);

    always_comb begin
        byte_sel = 8'h00;
        unique case (cnt_q)
            2'd0: byte_sel = wdata_q[31:24];
            2'd1: byte_sel = wdata_q[23:16];
            2'd2: byte_sel = wdata_q[15:8];
            2'd3: byte_sel = wdata_q[7:0];
            default: byte_sel = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        grant_d   = grant_q;
        last_d    = last_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        done0     = 1'b0;
        done1     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    state_d = XFER;
                    cnt_d   = 2'd0;
                    last_d  = pick1;
                    if (pick1) begin
                        word_d  = addr1[ADDR_W-1:2];
                        we_d    = we1;
                        wdata_d = wdata1;
                        grant_d = 2'b10;
                    end else begin
                        word_d  = addr0[ADDR_W-1:2];
                        we_d    = we0;
                        wdata_d = wdata0;
                        grant_d = 2'b01;
                    end
                end
            end
            XFER: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = {word_q, cnt_q};
                mem_wdata = we_q ? byte_sel : 8'h00;
                cnt_d     = cnt_q + 2'd1;
                // Read bytes arrive one cycle after their strobe.
                if (!we_q && cnt_q != 2'd0) begin
                    rdata_d = {rdata_q[23:0], mem_rdata};
                end
                if (cnt_q == 2'd3) begin
                    state_d = LAST;
                end
            end
            LAST: begin
                if (!we_q) begin
                    rdata_d = {rdata_q[23:0], mem_rdata};
                end
                state_d = DONE;
            end
            DONE: begin
                done0   = grant_q[0];
                done1   = grant_q[1];
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            word_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign rdata = rdata_q;
    assign grant = grant_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a 4 KiB byte memory model
// that returns read data one cycle after the strobe.
module tb_dmem_port_arbiter;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [31:0]   wdata0, wdata1;
    logic          done0, done1;
    logic [31:0]   rdata;
    logic [1:0]    grant;
    logic          busy;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata = 8'h00;

    logic [7:0]    mem [0:4095];

    int checks = 0;
    int errors = 0;
    int n_done0 = 0;
    int n_done1 = 0;
    int order[$];
    logic [AW-1:0] addr_log[$];

    dmem_port_arbiter #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .done0     (done0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .done1     (done1),
        .rdata     (rdata),
        .grant     (grant),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    always @(negedge clk) begin
        if (done0) begin
            n_done0++;
            order.push_back(0);
        end
        if (done1) begin
            n_done1++;
            order.push_back(1);
        end
        if (mem_en) addr_log.push_back(mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input int p, input logic we, input logic [AW-1:0] a,
                        input logic [31:0] wd, input logic tamper,
                        output int lat, output logic [1:0] g);
        logic d;
        @(negedge clk);
        if (p == 0) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd;
        end
        lat = 0;
        g   = 2'b00;
        d   = 1'b0;
        while (!d && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 2) g = grant;
            if (tamper && lat == 1) begin
                addr0 = 12'h070; wdata0 = 32'h0; we0 = 1'b0; req0 = 1'b0;
            end
            d = (p == 0) ? done0 : done1;
        end
        if (p == 0) req0 = 1'b0;
        else        req1 = 1'b0;
    endtask

    int         lat;
    logic [1:0] g;
    int         d0, d1, cyc;

    initial begin
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

        #12;
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {30'd0, done1, done0}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_addr", {20'd0, mem_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // CPU write
        d1 = n_done1;
        xfer(0, 1'b1, 12'h004, 32'hDEADBEEF, 1'b0, lat, g);
        chk("wr_lat", lat, 6);
        chk("wr_grant", {30'd0, g}, 32'h1);
        repeat (3) @(negedge clk);
        #1;
        chk("wr_bytes", {mem[4], mem[5], mem[6], mem[7]}, 32'hDEADBEEF);
        chk("wr_done0_once", n_done0, 1);
        chk("wr_no_done1", n_done1 - d1, 0);

        // CPU read, then a write must not disturb rdata
        @(negedge clk);
        mem[8] = 8'h01; mem[9] = 8'h02; mem[10] = 8'h03; mem[11] = 8'h04;
        xfer(0, 1'b0, 12'h008, 32'h0, 1'b0, lat, g);
        chk("rd_lat", lat, 6);
        chk("rd_data", rdata, 32'h01020304);
        xfer(0, 1'b1, 12'h020, 32'h11112222, 1'b0, lat, g);
        chk("rd_hold", rdata, 32'h01020304);

        // Continuous conflict from a fresh reset
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        order.delete();
        d0 = n_done0;
        d1 = n_done1;
        req0 = 1; we0 = 1; addr0 = 12'h040; wdata0 = 32'hA1A2A3A4;
        req1 = 1; we1 = 1; addr1 = 12'h050; wdata1 = 32'hB1B2B3B4;
        cyc = 0;
        while (order.size() < 4 && cyc < 60) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        req0 = 0;
        req1 = 0;
        chk("rr_count", order.size(), 4);
        if (order.size() == 4) begin
            chk("rr_order", {order[0][7:0], order[1][7:0],
                             order[2][7:0], order[3][7:0]}, 32'h00010001);
        end
        chk("rr_done0", n_done0 - d0, 2);
        chk("rr_done1", n_done1 - d1, 2);
        chk("rr_cpu_bytes", {mem[64], mem[65], mem[66], mem[67]}, 32'hA1A2A3A4);
        chk("rr_uart_bytes", {mem[80], mem[81], mem[82], mem[83]}, 32'hB1B2B3B4);

        // UART unaligned read
        @(negedge clk);
        addr_log.delete();
        d0 = n_done0;
        xfer(1, 1'b0, 12'h00B, 32'h0, 1'b0, lat, g);
        chk("ur_lat", lat, 6);
        chk("ur_grant", {30'd0, g}, 32'h2);
        chk("ur_naddr", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            chk("ur_addrs", {addr_log[0][7:0], addr_log[1][7:0],
                             addr_log[2][7:0], addr_log[3][7:0]}, 32'h08090A0B);
        end
        chk("ur_data", rdata, 32'h01020304);
        chk("ur_no_done0", n_done0 - d0, 0);

        // Reset in the third byte cycle of a CPU write
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 12'h030; wdata0 = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        d0 = n_done0;
        rst = 1'b0;
        req0 = 0;
        #1;
        chk("ab_mem_en", {31'd0, mem_en}, 32'd0);
        chk("ab_grant", {30'd0, grant}, 32'd0);
        chk("ab_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        chk("ab_no_done0", n_done0 - d0, 0);
        chk("ab_partial", {mem[48], mem[49], mem[50], mem[51]}, 32'hCAFE0000);
        xfer(1, 1'b1, 12'h010, 32'h11223344, 1'b0, lat, g);
        chk("ab_uart_lat", lat, 6);
        chk("ab_uart_bytes", {mem[16], mem[17], mem[18], mem[19]}, 32'h11223344);

        // Inputs changed and request dropped after grant
        xfer(0, 1'b1, 12'h060, 32'h55667788, 1'b1, lat, g);
        chk("tm_lat", lat, 6);
        repeat (2) @(negedge clk);
        chk("tm_bytes", {mem[96], mem[97], mem[98], mem[99]}, 32'h55667788);
        chk("tm_untouched", {24'd0, mem[112]}, 32'd0);
        chk("tm_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
